// File: rtl/ram_pkg.sv
// Shared types and constants for the dual-port RAM with clear sequencer.
package ram_pkg;

  // States of the clear sequencer.
  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_CLEAR = 1'b1
  } clr_state_e;

  // Read-during-write result selection.
  localparam int RDW_OLD = 0;
  localparam int RDW_NEW = 1;

endpackage : ram_pkg

// File: rtl/ram_clr_seq.sv
// Clear sequencer: walks every address once, writing the fill value, and
// reports ownership of the array through o_busy.
module ram_clr_seq
  import ram_pkg::*;
#(
  parameter int AW         = 11,
  parameter int CLR_ON_RST = 1
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  input  logic          i_clr_req,
  output logic          o_clr_we,
  output logic [AW-1:0] o_clr_addr,
  output logic          o_busy
);

  localparam clr_state_e RST_STATE = (CLR_ON_RST != 0) ? ST_CLEAR : ST_IDLE;
  localparam logic       RST_BUSY  = (CLR_ON_RST != 0);

  clr_state_e    state_q, state_d;
  logic [AW-1:0] cnt_q, cnt_d;
  logic          busy_q, busy_d;

  // Next-state logic: requests are only honoured in IDLE, or on the final
  // clear edge where a still-high request chains straight into another pass.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    busy_d  = busy_q;
    case (state_q)
      ST_IDLE: begin
        if (i_clr_req) begin
          state_d = ST_CLEAR;
          busy_d  = 1'b1;
        end
      end
      ST_CLEAR: begin
        cnt_d = cnt_q + AW'(1);
        if (cnt_q == '1 && !i_clr_req) begin
          state_d = ST_IDLE;
          busy_d  = 1'b0;
        end
      end
      default: begin
        state_d = ST_IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  // State, counter and busy flag update on the falling edge of the master clock.
  always_ff @(negedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= RST_STATE;
      cnt_q   <= '0;
      busy_q  <= RST_BUSY;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
    end
  end

  assign o_clr_we   = (state_q == ST_CLEAR);
  assign o_clr_addr = cnt_q;
  assign o_busy     = busy_q;

endmodule : ram_clr_seq

// File: rtl/ram_dp_clr.sv
// Dual-port RAM: port A read/write (CPU), port B read-only (video scanner),
// with a hardware clear sequencer that takes over the write path while busy.
module ram_dp_clr
  import ram_pkg::*;
#(
  parameter int          AW         = 11,
  parameter int          DW         = 8,
  parameter int          CLR_ON_RST = 1,
  parameter logic [DW-1:0] CLR_VALUE = '0,
  parameter int          RDW_MODE   = RDW_OLD
) (
  input  logic          i_EMU_MCLK,
  input  logic          i_EMU_MRST_n,
  input  logic [AW-1:0] i_A_ADDR,
  input  logic [DW-1:0] i_A_DIN,
  input  logic          i_A_WR_n,
  input  logic          i_A_RD_n,
  output logic [DW-1:0] o_A_DOUT,
  input  logic [AW-1:0] i_B_ADDR,
  input  logic          i_B_RD_n,
  output logic [DW-1:0] o_B_DOUT,
  input  logic          i_CLR_REQ,
  output logic          o_BUSY
);

  localparam int   DEPTH      = 1 << AW;
  localparam logic RDW_IS_NEW = (RDW_MODE == RDW_NEW);

  logic          clr_we;
  logic [AW-1:0] clr_addr;
  logic          busy;

  logic          cpu_wr;
  logic          mem_we;
  logic [AW-1:0] mem_waddr;
  logic [DW-1:0] mem_wdata;

  logic [DW-1:0] mem_q [0:DEPTH-1];
  logic [DW-1:0] a_dout_q, a_dout_d;
  logic [DW-1:0] b_dout_q, b_dout_d;

  ram_clr_seq #(
    .AW         (AW),
    .CLR_ON_RST (CLR_ON_RST)
  ) u_clr_seq (
    .i_clk      (i_EMU_MCLK),
    .i_rst_n    (i_EMU_MRST_n),
    .i_clr_req  (i_CLR_REQ),
    .o_clr_we   (clr_we),
    .o_clr_addr (clr_addr),
    .o_busy     (busy)
  );

  // CPU writes are dropped outright while the sequencer owns the array.
  assign cpu_wr = !i_A_WR_n && !clr_we;

  // Write-port mux: sequencer has the array during a clear, CPU otherwise.
  always_comb begin
    mem_we    = 1'b0;
    mem_waddr = i_A_ADDR;
    mem_wdata = i_A_DIN;
    if (clr_we) begin
      mem_we    = 1'b1;
      mem_waddr = clr_addr;
      mem_wdata = CLR_VALUE;
    end else if (cpu_wr) begin
      mem_we    = 1'b1;
    end
  end

  // Read-data selection for both ports, including the collision bypass.
  always_comb begin
    a_dout_d = a_dout_q;
    b_dout_d = b_dout_q;
    if (!i_A_RD_n) begin
      if (clr_we)
        a_dout_d = CLR_VALUE;
      else if (cpu_wr && RDW_IS_NEW)
        a_dout_d = i_A_DIN;
      else
        a_dout_d = mem_q[i_A_ADDR];
    end
    if (!i_B_RD_n) begin
      if (clr_we)
        b_dout_d = CLR_VALUE;
      else if (cpu_wr && RDW_IS_NEW && (i_B_ADDR == i_A_ADDR))
        b_dout_d = i_A_DIN;
      else
        b_dout_d = mem_q[i_B_ADDR];
    end
  end

  // Storage array; deliberately not reset.
  always_ff @(negedge i_EMU_MCLK) begin
    if (mem_we)
      mem_q[mem_waddr] <= mem_wdata;
  end

  // Read-data registers, held while the strobe is inactive.
  always_ff @(negedge i_EMU_MCLK or negedge i_EMU_MRST_n) begin
    if (!i_EMU_MRST_n) begin
      a_dout_q <= '0;
      b_dout_q <= '0;
    end else begin
      a_dout_q <= a_dout_d;
      b_dout_q <= b_dout_d;
    end
  end

  assign o_A_DOUT = a_dout_q;
  assign o_B_DOUT = b_dout_q;
  assign o_BUSY   = busy;

endmodule : ram_dp_clr

// File: tb/tb_ram_dp_clr.sv
// Directed bench for ram_dp_clr. Three instances share stimulus:
//   dut0: defaults (old-data collisions, fill 00, clear on reset)
//   dut1: new-data collisions, fill FF, clear on reset
//   dut2: no clear on reset
module tb_ram_dp_clr;

  logic        clk;
  logic        rst_n;
  logic [10:0] a_addr;
  logic [7:0]  a_din;
  logic        a_wr_n;
  logic        a_rd_n;
  logic [10:0] b_addr;
  logic        b_rd_n;
  logic        clr_req;

  logic [7:0]  a_dout0, a_dout1, a_dout2;
  logic [7:0]  b_dout0, b_dout1, b_dout2;
  logic        busy0, busy1, busy2;

  int checks   = 0;
  int failures = 0;
  int e;

  ram_dp_clr #(.AW(11), .DW(8), .CLR_ON_RST(1), .CLR_VALUE(8'h00), .RDW_MODE(0)) dut0 (
    .i_EMU_MCLK(clk), .i_EMU_MRST_n(rst_n),
    .i_A_ADDR(a_addr), .i_A_DIN(a_din), .i_A_WR_n(a_wr_n), .i_A_RD_n(a_rd_n), .o_A_DOUT(a_dout0),
    .i_B_ADDR(b_addr), .i_B_RD_n(b_rd_n), .o_B_DOUT(b_dout0),
    .i_CLR_REQ(clr_req), .o_BUSY(busy0));

  ram_dp_clr #(.AW(11), .DW(8), .CLR_ON_RST(1), .CLR_VALUE(8'hFF), .RDW_MODE(1)) dut1 (
    .i_EMU_MCLK(clk), .i_EMU_MRST_n(rst_n),
    .i_A_ADDR(a_addr), .i_A_DIN(a_din), .i_A_WR_n(a_wr_n), .i_A_RD_n(a_rd_n), .o_A_DOUT(a_dout1),
    .i_B_ADDR(b_addr), .i_B_RD_n(b_rd_n), .o_B_DOUT(b_dout1),
    .i_CLR_REQ(clr_req), .o_BUSY(busy1));

  ram_dp_clr #(.AW(11), .DW(8), .CLR_ON_RST(0), .CLR_VALUE(8'h00), .RDW_MODE(0)) dut2 (
    .i_EMU_MCLK(clk), .i_EMU_MRST_n(rst_n),
    .i_A_ADDR(a_addr), .i_A_DIN(a_din), .i_A_WR_n(a_wr_n), .i_A_RD_n(a_rd_n), .o_A_DOUT(a_dout2),
    .i_B_ADDR(b_addr), .i_B_RD_n(b_rd_n), .o_B_DOUT(b_dout2),
    .i_CLR_REQ(clr_req), .o_BUSY(busy2));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic check(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance until dut0 drops busy, bounded so a stuck sequencer cannot hang.
  task automatic wait_idle(inout int n);
    while (busy0 === 1'b1 && n < 4000) begin
      tick();
      n++;
    end
  endtask

  initial begin
    rst_n   = 1'b0;
    a_addr  = '0;
    a_din   = '0;
    a_wr_n  = 1'b1;
    a_rd_n  = 1'b1;
    b_addr  = '0;
    b_rd_n  = 1'b1;
    clr_req = 1'b0;
    repeat (3) tick();

    // Reset state
    check("rst_busy0", int'(busy0), 1);
    check("rst_busy1", int'(busy1), 1);
    check("rst_busy2", int'(busy2), 0);
    check("rst_adout0", int'(a_dout0), 0);
    check("rst_bdout0", int'(b_dout0), 0);

    // Release; dut2 accepts a write on the very first edge
    rst_n  = 1'b1;
    a_addr = 11'h7FF;
    a_din  = 8'h3C;
    a_wr_n = 1'b0;
    tick();
    check("noclr_busy2", int'(busy2), 0);
    a_wr_n = 1'b1;
    a_rd_n = 1'b0;
    tick();
    check("noclr_rd2", int'(a_dout2), 'h3C);
    check("busy_rd_fill1", int'(a_dout1), 'hFF);
    check("busy_rd_fill0", int'(a_dout0), 'h00);
    a_rd_n = 1'b1;
    e = 2;
    wait_idle(e);
    check("rst_clear_len", e, 2048);
    check("rst_clear_busy1", int'(busy1), 0);

    // Cleared contents at both ends of the array
    b_addr = 11'h7FF;
    b_rd_n = 1'b0;
    tick();
    check("b_7ff_0", int'(b_dout0), 'h00);
    check("b_7ff_1", int'(b_dout1), 'hFF);
    check("b_7ff_2", int'(b_dout2), 'h3C);
    b_addr = 11'h000;
    tick();
    check("b_000_0", int'(b_dout0), 'h00);
    check("b_000_1", int'(b_dout1), 'hFF);
    b_rd_n = 1'b1;

    // Write on A, read back on B, then hold
    a_addr = 11'h123;
    a_din  = 8'hA5;
    a_wr_n = 1'b0;
    tick();
    a_wr_n = 1'b1;
    b_addr = 11'h123;
    b_rd_n = 1'b0;
    tick();
    check("b_rd_123_0", int'(b_dout0), 'hA5);
    check("b_rd_123_1", int'(b_dout1), 'hA5);
    b_rd_n = 1'b1;
    b_addr = 11'h456;
    tick();
    check("b_hold_0", int'(b_dout0), 'hA5);
    check("b_hold_1", int'(b_dout1), 'hA5);

    // Read-during-write collision at 0x010 on both ports
    a_addr = 11'h010;
    a_din  = 8'h11;
    a_wr_n = 1'b0;
    tick();
    a_din  = 8'h5A;
    a_rd_n = 1'b0;
    b_addr = 11'h010;
    b_rd_n = 1'b0;
    tick();
    check("rdw_b_old", int'(b_dout0), 'h11);
    check("rdw_b_new", int'(b_dout1), 'h5A);
    check("rdw_a_old", int'(a_dout0), 'h11);
    check("rdw_a_new", int'(a_dout1), 'h5A);
    a_wr_n = 1'b1;
    a_rd_n = 1'b1;
    tick();
    check("rdw_after_0", int'(b_dout0), 'h5A);
    check("rdw_after_1", int'(b_dout1), 'h5A);
    b_rd_n = 1'b1;

    // Requested clear: writes dropped, reads return the fill value
    a_addr = 11'h200;
    a_din  = 8'h33;
    a_wr_n = 1'b0;
    tick();
    a_wr_n  = 1'b1;
    clr_req = 1'b1;
    tick();
    check("req_busy0", int'(busy0), 1);
    check("req_busy1", int'(busy1), 1);
    clr_req = 1'b0;
    a_din   = 8'h77;
    a_wr_n  = 1'b0;
    tick();
    a_addr = 11'h000;
    tick();
    a_wr_n = 1'b1;
    a_addr = 11'h200;
    a_rd_n = 1'b0;
    tick();
    check("clr_rd_fill1", int'(a_dout1), 'hFF);
    check("clr_rd_fill0", int'(a_dout0), 'h00);
    a_rd_n = 1'b1;
    e = 3;
    wait_idle(e);
    check("req_clear_len", e, 2048);
    a_rd_n = 1'b0;
    tick();
    check("after_clr_200_1", int'(a_dout1), 'hFF);
    check("after_clr_200_0", int'(a_dout0), 'h00);
    a_addr = 11'h000;
    tick();
    check("dropped_wr_000_1", int'(a_dout1), 'hFF);
    check("dropped_wr_000_0", int'(a_dout0), 'h00);
    a_rd_n = 1'b1;

    // Reset in the middle of a clear
    clr_req = 1'b1;
    tick();
    clr_req = 1'b0;
    repeat (999) tick();
    check("mid_busy_pre", int'(busy0), 1);
    #1;
    rst_n = 1'b0;
    #1;
    check("mid_rst_busy0", int'(busy0), 1);
    check("mid_rst_busy2", int'(busy2), 0);
    check("mid_rst_adout1", int'(a_dout1), 0);
    tick();
    tick();
    rst_n = 1'b1;
    e = 0;
    wait_idle(e);
    check("mid_rst_clear_len", e, 2048);

    // Request held high: passes chain with no idle edge between them
    clr_req = 1'b1;
    tick();
    repeat (2048) tick();
    check("b2b_busy", int'(busy0), 1);
    clr_req = 1'b0;
    e = 0;
    wait_idle(e);
    check("b2b_second_len", e, 2048);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_ram_dp_clr
